// File: rtl/trig_capture_ctrl.sv
// Capture/trigger sequencer for a circular sample RAM. It fills a pre-trigger window,
// arms the channel triggers, latches the trigger sample and stores the post-trigger tail.
module trig_capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CH1Trig,
    input  logic              CH2Trig,
    input  logic              CH3Trig,
    input  logic              CH4Trig,
    input  logic              CH5Trig,
    input  logic              protTrig,
    input  logic              smpl_en,
    input  logic              capture_start,
    input  logic              clr_done,
    input  logic [ADDR_W-1:0] trig_pos,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] tpos_eff;
    logic [ADDR_W-1:0] pre_len;
    logic [ADDR_W-1:0] waddr_nxt;
    logic              trig_all;

    // Post-trigger length is forced into 1..ENTRIES-1 so the pre window is never empty.
    always_comb begin
        tpos_eff = trig_pos;
        if (trig_pos == '0)
            tpos_eff = ONE;
        else if (trig_pos > LAST)
            tpos_eff = LAST;
        pre_len = ADDR_W'(ENTRIES) - tpos_eff;
    end

    assign trig_all  = CH1Trig & CH2Trig & CH3Trig & CH4Trig & CH5Trig & protTrig;
    assign we        = smpl_en & ((state == S_PRE) || (state == S_WAIT) || (state == S_POST));
    assign waddr_nxt = (waddr == LAST) ? '0 : waddr + ONE;

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block
    // and wins over everything else, including a write that would happen that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
            waddr        <= '0;
            trig_addr    <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
        end else begin
            if (we)
                waddr <= waddr_nxt;

            unique case (state)
                S_IDLE: begin
                    if (capture_start) begin
                        state     <= S_PRE;
                        pre_cnt   <= '0;
                        triggered <= 1'b0;
                    end
                end
                S_PRE: begin
                    if (smpl_en) begin
                        pre_cnt <= pre_cnt + ONE;
                        if (pre_cnt == pre_len - ONE) begin
                            state <= S_WAIT;
                            armed <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (smpl_en && trig_all) begin
                        trig_addr <= waddr;
                        triggered <= 1'b1;
                        post_cnt  <= ONE;
                        if (tpos_eff == ONE) begin
                            state        <= S_DONE;
                            armed        <= 1'b0;
                            capture_done <= 1'b1;
                        end else begin
                            state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (smpl_en) begin
                        post_cnt <= post_cnt + ONE;
                        if (post_cnt == tpos_eff - ONE) begin
                            state        <= S_DONE;
                            armed        <= 1'b0;
                            capture_done <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (capture_start) begin
                        state        <= S_PRE;
                        pre_cnt      <= '0;
                        triggered    <= 1'b0;
                        capture_done <= 1'b0;
                    end else if (clr_done) begin
                        state        <= S_IDLE;
                        capture_done <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Directed bench for trig_capture_ctrl with a 16-entry buffer and 5-bit addresses,
// so an out-of-range trig_pos can be driven.
module tb_trig_capture_ctrl;

    localparam int ENTRIES = 16;
    localparam int ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              CH1Trig, CH2Trig, CH3Trig, CH4Trig, CH5Trig, protTrig;
    logic              smpl_en, capture_start, clr_done;
    logic [ADDR_W-1:0] trig_pos;
    logic              armed, triggered, capture_done, we;
    logic [ADDR_W-1:0] waddr, trig_addr;

    int errors = 0;
    int checks = 0;
    logic we_s;

    trig_capture_ctrl #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .CH1Trig       (CH1Trig),
        .CH2Trig       (CH2Trig),
        .CH3Trig       (CH3Trig),
        .CH4Trig       (CH4Trig),
        .CH5Trig       (CH5Trig),
        .protTrig      (protTrig),
        .smpl_en       (smpl_en),
        .capture_start (capture_start),
        .clr_done      (clr_done),
        .trig_pos      (trig_pos),
        .armed         (armed),
        .triggered     (triggered),
        .capture_done  (capture_done),
        .we            (we),
        .waddr         (waddr),
        .trig_addr     (trig_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive smpl_en, capture we before the edge, land 1 time unit after it.
    task automatic tick(input logic se);
        smpl_en = se;
        #1;
        we_s = we;
        @(posedge clk);
        #1;
    endtask

    task automatic writes(input int n);
        repeat (n) tick(1'b1);
    endtask

    task automatic set_trig(input logic v);
        CH1Trig = v; CH2Trig = v; CH3Trig = v; CH4Trig = v; CH5Trig = v; protTrig = v;
    endtask

    task automatic start_pulse(input logic se);
        capture_start = 1'b1;
        tick(se);
        capture_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; smpl_en = 1'b0; capture_start = 1'b0; clr_done = 1'b0;
        trig_pos = 5'd4;
        set_trig(1'b1);
        tick(1'b0);
        tick(1'b0);
        check("rst_armed", armed, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", capture_done, 0);
        check("rst_waddr", waddr, 0);
        check("rst_trig_addr", trig_addr, 0);
        rst_n = 1'b1;

        // Scenario 1: trig_pos=4 -> pre_len=12, trigger at address 12, done at waddr 0.
        start_pulse(1'b1);
        check("s1_no_we_in_idle", we_s, 0);
        writes(11);
        check("s1_armed_after_11", armed, 0);
        writes(1);
        check("s1_armed_after_12", armed, 1);
        check("s1_waddr_12", waddr, 12);
        writes(1);
        check("s1_triggered", triggered, 1);
        check("s1_trig_addr", trig_addr, 12);
        check("s1_not_done_yet", capture_done, 0);
        writes(2);
        check("s1_done_early", capture_done, 0);
        writes(1);
        check("s1_done", capture_done, 1);
        check("s1_armed_off", armed, 0);
        check("s1_waddr_wrap", waddr, 0);
        tick(1'b1);
        check("s1_no_we_in_done", we_s, 0);
        check("s1_waddr_hold", waddr, 0);

        // Scenario 2: clr_done, then long WAIT with wrap, stray capture_start ignored.
        clr_done = 1'b1;
        tick(1'b0);
        clr_done = 1'b0;
        check("s2_cleared", capture_done, 0);
        tick(1'b1);
        check("s2_idle_no_we", we_s, 0);
        set_trig(1'b1);
        CH3Trig = 1'b0;
        start_pulse(1'b0);
        writes(12);
        check("s2_armed", armed, 1);
        writes(30);
        check("s2_wait_no_trig", triggered, 0);
        check("s2_wait_armed", armed, 1);
        check("s2_waddr_wrapped", waddr, 10);
        start_pulse(1'b0);
        check("s2_start_in_wait_armed", armed, 1);
        check("s2_start_in_wait_trig", triggered, 0);
        CH3Trig = 1'b1;
        writes(1);
        CH3Trig = 1'b0;
        check("s2_trig_addr", trig_addr, 10);
        check("s2_triggered", triggered, 1);
        writes(2);
        check("s2_done_early", capture_done, 0);
        writes(1);
        check("s2_done", capture_done, 1);
        check("s2_waddr", waddr, 14);

        // Scenario 3a: clr_done + capture_start together, trig_pos=1 -> pre_len=15.
        set_trig(1'b1);
        trig_pos = 5'd1;
        clr_done = 1'b1;
        start_pulse(1'b0);
        clr_done = 1'b0;
        check("s3a_done_cleared", capture_done, 0);
        check("s3a_triggered_cleared", triggered, 0);
        writes(14);
        check("s3a_armed_after_14", armed, 0);
        writes(1);
        check("s3a_armed_after_15", armed, 1);
        writes(1);
        check("s3a_done_on_trigger", capture_done, 1);
        check("s3a_trig_addr", trig_addr, 13);
        check("s3a_waddr", waddr, 14);
        check("s3a_armed_off", armed, 0);

        // Scenario 3b: trig_pos=0 behaves as 1; restart straight from DONE.
        trig_pos = 5'd0;
        start_pulse(1'b0);
        check("s3b_started", capture_done, 0);
        writes(15);
        check("s3b_armed", armed, 1);
        writes(1);
        check("s3b_done", capture_done, 1);
        check("s3b_trig_addr", trig_addr, 13);

        // Scenario 3c: trig_pos=20 clamps to 15 -> pre_len=1.
        trig_pos = 5'd20;
        start_pulse(1'b0);
        writes(1);
        check("s3c_armed_after_1", armed, 1);
        writes(1);
        check("s3c_trig_addr", trig_addr, 15);
        writes(13);
        check("s3c_done_early", capture_done, 0);
        writes(1);
        check("s3c_done", capture_done, 1);
        check("s3c_waddr", waddr, 14);

        // Scenario 4: triggers only in PRE, then only without smpl_en in WAIT.
        trig_pos = 5'd4;
        start_pulse(1'b0);
        writes(12);
        check("s4_armed", armed, 1);
        check("s4_not_triggered_pre", triggered, 0);
        repeat (5) tick(1'b0);
        check("s4_we_low", we_s, 0);
        check("s4_no_trig_without_smpl", triggered, 0);
        check("s4_waddr_hold", waddr, 10);
        set_trig(1'b0);
        writes(3);
        check("s4_we_high", we_s, 1);
        check("s4_still_waiting", triggered, 0);
        check("s4_still_armed", armed, 1);
        check("s4_waddr", waddr, 13);

        // Scenario 5: trigger, one POST write, then reset mid-POST.
        set_trig(1'b1);
        writes(1);
        check("s5_trig_addr", trig_addr, 13);
        writes(1);
        rst_n = 1'b0;
        tick(1'b1);
        rst_n = 1'b1;
        check("s5_rst_armed", armed, 0);
        check("s5_rst_triggered", triggered, 0);
        check("s5_rst_done", capture_done, 0);
        check("s5_rst_waddr", waddr, 0);
        check("s5_rst_trig_addr", trig_addr, 0);
        tick(1'b1);
        check("s5_idle_no_we", we_s, 0);
        start_pulse(1'b1);
        writes(11);
        check("s5_armed_after_11", armed, 0);
        writes(1);
        check("s5_armed_after_12", armed, 1);
        writes(1);
        check("s5_trig_addr_again", trig_addr, 12);
        writes(3);
        check("s5_done", capture_done, 1);
        check("s5_waddr", waddr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
